// File: rtl/serial_8bits_align_c_if.sv
// Byte-aligner lane interface: serial input plus the registered byte stream
// handed to the 8-bit to 32-bit word packer.
interface serial_8bits_align_c_if;
  logic       serial_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  // Stimulus / PHY side drives the lane and watches the byte stream.
  modport master (
    output serial_in,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active
  );

  // Aligner side consumes the lane and produces the byte stream.
  modport slave (
    input  serial_in,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active
  );
endinterface

// File: rtl/serial_8bits_align_c.sv
// Serial lane deserialiser with COMMA-based byte alignment.
// Hunts bit-by-bit for COMMA, confirms alignment over LOCK_COUNT consecutive
// aligned commas, then emits bytes with a per-byte strobe; valid_out marks
// data bytes (not COMMA fill) while the link is active.
// Optional feature macro: SER_RELOCK_EN -- drop lock after MAX_GAP consecutive
// non-COMMA bytes and hunt again. Without it, ACTIVE holds until reset.
module serial_8bits_align_c #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MAX_GAP    = 16
) (
  input logic                    clk_32f_c,
  input logic                    reset,
  serial_8bits_align_c_if.slave  bus
);

  localparam logic [1:0] StHunt   = 2'd0;
  localparam logic [1:0] StCount  = 2'd1;
  localparam logic [1:0] StActive = 2'd2;

  // Parameter range sanity, caught at elaboration.
  if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock_count
    $error("LOCK_COUNT must be in 1..15");
  end
  if (MAX_GAP < 1 || MAX_GAP > 255) begin : g_bad_max_gap
    $error("MAX_GAP must be in 1..255");
  end

  logic [1:0] state_q, state_d;
  // Only the low 7 bits of the shift register ever feed the next window.
  logic [6:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;

  logic [7:0] win;
  logic       win_comma;
  logic       byte_done;
  logic       lock_hit;
  logic       gap_expired;

  assign win       = {sr_q, bus.serial_in};
  assign win_comma = (win == COMMA);
  assign byte_done = (bit_cnt_q == 3'd7);
  assign lock_hit  = ((32'(comma_cnt_q) + 32'd1) == LOCK_COUNT);

`ifdef SER_RELOCK_EN
  localparam logic [7:0] GapLimit = 8'(MAX_GAP);

  logic [7:0] gap_cnt_q, gap_cnt_d;

  // Limit was reached on the previous byte; that byte already went out valid.
  assign gap_expired = (gap_cnt_q == GapLimit);
`else
  assign gap_expired = 1'b0;
`endif

  // Next-state: alignment FSM, byte assembly and output registers.
  always_comb begin
    state_d     = state_q;
    sr_d        = win[6:0];
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    strobe_d    = 1'b0;
    active_d    = active_q;
`ifdef SER_RELOCK_EN
    gap_cnt_d   = gap_cnt_q;
`endif

    case (state_q)
      StHunt: begin
        // Bit-granular search: the comma found here defines the byte boundary.
        if (win_comma) begin
          bit_cnt_d   = 3'd0;
          comma_cnt_d = 4'd1;
          if (LOCK_COUNT == 1) begin
            state_d  = StActive;
            active_d = 1'b1;
`ifdef SER_RELOCK_EN
            gap_cnt_d = 8'd0;
`endif
          end else begin
            state_d = StCount;
          end
        end
      end

      StCount: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          strobe_d = 1'b1;
          data_d   = win;
          valid_d  = 1'b0;
          if (win_comma) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (lock_hit) begin
              state_d  = StActive;
              active_d = 1'b1;
`ifdef SER_RELOCK_EN
              gap_cnt_d = 8'd0;
`endif
            end
          end else begin
            state_d     = StHunt;
            comma_cnt_d = 4'd0;
          end
        end
      end

      StActive: begin
        if (gap_expired) begin
          state_d     = StHunt;
          active_d    = 1'b0;
          valid_d     = 1'b0;
          comma_cnt_d = 4'd0;
        end else begin
          // Alignment is frozen: only the current boundary is ever examined.
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) begin
            strobe_d = 1'b1;
            data_d   = win;
            valid_d  = !win_comma;
`ifdef SER_RELOCK_EN
            if (win_comma) begin
              gap_cnt_d = 8'd0;
            end else if (gap_cnt_q != GapLimit) begin
              gap_cnt_d = gap_cnt_q + 8'd1;
            end
`endif
          end
        end
      end

      default: begin
        state_d = StHunt;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_32f_c) begin
    if (reset) begin
      state_q     <= StHunt;
      sr_q        <= 7'd0;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= 4'd0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      strobe_q    <= strobe_d;
      active_q    <= active_d;
    end
  end

`ifdef SER_RELOCK_EN
  // Gap counter register, cleared with the rest of the state on reset.
  always_ff @(posedge clk_32f_c) begin
    if (reset) begin
      gap_cnt_q <= 8'd0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end
`endif

  assign bus.data_out    = data_q;
  assign bus.valid_out   = valid_q;
  assign bus.byte_strobe = strobe_q;
  assign bus.active      = active_q;

endmodule

// File: tb/tb_serial_8bits_align_c.sv
// Directed bench for serial_8bits_align_c: reset, lock, data, failed lock,
// frozen alignment, reset while active and (with SER_RELOCK_EN) gap relock.
module tb_serial_8bits_align_c;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  int   strobe_cnt;
  logic valid_seen;

  serial_8bits_align_c_if bus ();

  serial_8bits_align_c dut (
    .clk_32f_c (clk),
    .reset     (reset),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bit per clock: drive on negedge, observe 1 time unit after posedge.
  task automatic tick(input logic b);
    @(negedge clk);
    bus.serial_in = b;
    @(posedge clk);
    #1;
    if (bus.byte_strobe === 1'b1) strobe_cnt++;
    if (bus.valid_out === 1'b1) valid_seen = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) tick(v[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0);
    tick(1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (bus.active !== 1'b0) $display("FAIL reset_active got %b expected 0", bus.active);
    else pass_cnt++;
    total_cnt++;
    if (bus.valid_out !== 1'b0) $display("FAIL reset_valid got %b expected 0", bus.valid_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_out !== 8'h00) $display("FAIL reset_data got %h expected 00", bus.data_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.byte_strobe !== 1'b0) $display("FAIL reset_strobe got %b expected 0", bus.byte_strobe);
    else pass_cnt++;
  endtask

  task automatic test_lock();
    strobe_cnt = 0;
    valid_seen = 1'b0;
    tick(1'b0); tick(1'b0); tick(1'b0);
    send_byte(8'hBC);
    total_cnt++;
    if (strobe_cnt !== 0) $display("FAIL lock_first_no_strobe got %0d expected 0", strobe_cnt);
    else pass_cnt++;
    send_byte(8'hBC);
    send_byte(8'hBC);
    total_cnt++;
    if (strobe_cnt !== 2) $display("FAIL lock_strobes_3 got %0d expected 2", strobe_cnt);
    else pass_cnt++;
    total_cnt++;
    if (bus.active !== 1'b0) $display("FAIL lock_not_yet got %b expected 0", bus.active);
    else pass_cnt++;
    send_byte(8'hBC);
    total_cnt++;
    if (strobe_cnt !== 3) $display("FAIL lock_strobes_4 got %0d expected 3", strobe_cnt);
    else pass_cnt++;
    total_cnt++;
    if (bus.active !== 1'b1) $display("FAIL lock_active got %b expected 1", bus.active);
    else pass_cnt++;
    total_cnt++;
    if (bus.byte_strobe !== 1'b1) $display("FAIL lock_strobe_4th got %b expected 1", bus.byte_strobe);
    else pass_cnt++;
    total_cnt++;
    if (valid_seen !== 1'b0) $display("FAIL lock_valid_low got %b expected 0", valid_seen);
    else pass_cnt++;
  endtask

  task automatic test_data();
    logic [7:0] bytes [6];
    logic       exp_v [6];
    logic [7:0] prev;
    bytes = '{8'hBC, 8'hBC, 8'hA5, 8'h3C, 8'hFF, 8'hBC};
    exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    prev  = 8'hBC;
    for (int i = 0; i < 6; i++) begin
      strobe_cnt = 0;
      tick(bytes[i][7]);
      total_cnt++;
      if (bus.data_out !== prev || bus.byte_strobe !== 1'b0)
        $display("FAIL data_hold_%0d got %h/%b expected %h/0", i, bus.data_out,
                 bus.byte_strobe, prev);
      else pass_cnt++;
      for (int b = 6; b >= 0; b--) tick(bytes[i][b]);
      total_cnt++;
      if (bus.data_out !== bytes[i]) $display("FAIL data_byte_%0d got %h expected %h", i,
                                              bus.data_out, bytes[i]);
      else pass_cnt++;
      total_cnt++;
      if (bus.valid_out !== exp_v[i]) $display("FAIL data_valid_%0d got %b expected %b", i,
                                               bus.valid_out, exp_v[i]);
      else pass_cnt++;
      total_cnt++;
      if (strobe_cnt !== 1) $display("FAIL data_strobes_%0d got %0d expected 1", i, strobe_cnt);
      else pass_cnt++;
      prev = bytes[i];
    end
  endtask

  task automatic test_failed_lock();
    do_reset();
    tick(1'b0); tick(1'b0); tick(1'b0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h11);
    total_cnt++;
    if (bus.active !== 1'b0) $display("FAIL fail_active got %b expected 0", bus.active);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_out !== 8'h11 || bus.valid_out !== 1'b0 || bus.byte_strobe !== 1'b1)
      $display("FAIL fail_byte got %h/%b/%b expected 11/0/1", bus.data_out, bus.valid_out,
               bus.byte_strobe);
    else pass_cnt++;
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    total_cnt++;
    if (bus.active !== 1'b0) $display("FAIL fail_relock_early got %b expected 0", bus.active);
    else pass_cnt++;
    send_byte(8'hBC);
    total_cnt++;
    if (bus.active !== 1'b1) $display("FAIL fail_relock got %b expected 1", bus.active);
    else pass_cnt++;
  endtask

  // Stream 000 + 4x BC on the old boundaries gives 17, 97, 97, 97.
  task automatic test_misaligned();
    logic [7:0] bcs;
    bcs = 8'hBC;
    strobe_cnt = 0;
    tick(1'b0); tick(1'b0); tick(1'b0);
    for (int b = 7; b >= 3; b--) tick(bcs[b]);
    total_cnt++;
    if (bus.data_out !== 8'h17 || bus.valid_out !== 1'b1)
      $display("FAIL mis_first got %h/%b expected 17/1", bus.data_out, bus.valid_out);
    else pass_cnt++;
    for (int b = 2; b >= 0; b--) tick(bcs[b]);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    total_cnt++;
    if (strobe_cnt !== 4) $display("FAIL mis_strobes got %0d expected 4", strobe_cnt);
    else pass_cnt++;
    total_cnt++;
    if (bus.active !== 1'b1) $display("FAIL mis_active got %b expected 1", bus.active);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_out !== 8'h97 || bus.valid_out !== 1'b1)
      $display("FAIL mis_last got %h/%b expected 97/1", bus.data_out, bus.valid_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    total_cnt++;
    if (bus.active !== 1'b0 || bus.valid_out !== 1'b0 || bus.data_out !== 8'h00 ||
        bus.byte_strobe !== 1'b0)
      $display("FAIL mid_reset got %b/%b/%h/%b expected 0/0/00/0", bus.active, bus.valid_out,
               bus.data_out, bus.byte_strobe);
    else pass_cnt++;
    strobe_cnt = 0;
    send_byte(8'h00);
    total_cnt++;
    if (strobe_cnt !== 0 || bus.active !== 1'b0)
      $display("FAIL mid_after got %0d/%b expected 0/0", strobe_cnt, bus.active);
    else pass_cnt++;
  endtask

`ifdef SER_RELOCK_EN
  task automatic test_relock();
    logic [7:0] d55;
    d55 = 8'h55;
    do_reset();
    tick(1'b0); tick(1'b0); tick(1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    for (int i = 1; i <= 15; i++) begin
      send_byte(8'h55);
      total_cnt++;
      if (bus.active !== 1'b1 || bus.valid_out !== 1'b1)
        $display("FAIL gap_byte_%0d got %b/%b expected 1/1", i, bus.active, bus.valid_out);
      else pass_cnt++;
    end
    send_byte(8'h55);
    total_cnt++;
    if (bus.active !== 1'b1 || bus.valid_out !== 1'b1 || bus.byte_strobe !== 1'b1)
      $display("FAIL gap_byte_16 got %b/%b/%b expected 1/1/1", bus.active, bus.valid_out,
               bus.byte_strobe);
    else pass_cnt++;
    tick(d55[7]);
    total_cnt++;
    if (bus.active !== 1'b0 || bus.valid_out !== 1'b0)
      $display("FAIL gap_drop got %b/%b expected 0/0", bus.active, bus.valid_out);
    else pass_cnt++;
    for (int b = 6; b >= 0; b--) tick(d55[b]);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    total_cnt++;
    if (bus.active !== 1'b0) $display("FAIL gap_relock_early got %b expected 0", bus.active);
    else pass_cnt++;
    send_byte(8'hBC);
    total_cnt++;
    if (bus.active !== 1'b1) $display("FAIL gap_relock got %b expected 1", bus.active);
    else pass_cnt++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    strobe_cnt    = 0;
    valid_seen    = 1'b0;
    reset         = 1'b1;
    bus.serial_in = 1'b0;
    test_reset();
    test_lock();
    test_data();
    test_failed_lock();
    test_misaligned();
    test_reset_mid();
`ifdef SER_RELOCK_EN
    test_relock();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
